// File: rtl/udp_tx.sv
// UDP transmit framer: buffers one payload while summing it, then emits an
// 8-byte big-endian UDP header followed by the payload on a valid-only stream.
// state   | meaning
// IDLE    | waiting for start
// LOAD    | accepting payload bytes into the buffer, accumulating checksum
// CSUM    | add length, fold, complement
// HEADER  | emitting the 8 header bytes
// PAYLOAD | emitting buffered payload, then one cycle to drop valid/busy
module udp_tx #(
   parameter int          DATA_WIDTH  = 8,
   parameter logic [15:0] LOCAL_PORT  = 16'd5678,
   parameter int          MAX_PAYLOAD = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [15:0]           dst_port,
   input  logic [DATA_WIDTH-1:0] payload_in,
   input  logic                  payload_valid_in,
   input  logic                  payload_last,
   output logic                  ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  busy,
   output logic                  error
);

   localparam int CW = $clog2(MAX_PAYLOAD + 1);
   localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CSUM, S_HEADER, S_PAYLOAD} state_t;

   state_t        state_q;
   logic [15:0]   dst_q;
   logic [CW-1:0] n_q;
   logic [CW-1:0] rd_q;
   logic [31:0]   acc_q;
   logic [15:0]   len_q;
   logic [15:0]   csum_q;
   logic [2:0]    hdr_idx_q;
   logic [7:0]    data_q;
   logic          valid_q;
   logic          ready_q;
   logic          busy_q;
   logic          error_q;
   logic [7:0]    buf_q [2**AW];

   logic          accept;
   logic          full;
   logic [31:0]   word_add;
   logic [15:0]   len_d;
   logic [31:0]   sum_d;
   logic [16:0]   fold1_d;
   logic [15:0]   fold2_d;
   logic [7:0]    hdr_byte;
   logic [7:0]    rd_byte;

   // Even byte index is the high half of a 16-bit word; odd-length payloads pad with zero.
   always_comb begin
      accept   = (state_q == S_LOAD) && payload_valid_in;
      full     = (n_q == CW'(MAX_PAYLOAD));
      word_add = n_q[0] ? {24'h0, payload_in} : {16'h0, payload_in, 8'h00};
      len_d    = 16'(n_q) + 16'd8;
      sum_d    = acc_q + {16'h0, len_d};
      fold1_d  = {1'b0, sum_d[15:0]} + {1'b0, sum_d[31:16]};
      fold2_d  = fold1_d[15:0] + {15'h0, fold1_d[16]};
      rd_byte  = buf_q[rd_q[AW-1:0]];
      case (hdr_idx_q)
         3'd0:    hdr_byte = LOCAL_PORT[15:8];
         3'd1:    hdr_byte = LOCAL_PORT[7:0];
         3'd2:    hdr_byte = dst_q[15:8];
         3'd3:    hdr_byte = dst_q[7:0];
         3'd4:    hdr_byte = len_q[15:8];
         3'd5:    hdr_byte = len_q[7:0];
         3'd6:    hdr_byte = csum_q[15:8];
         default: hdr_byte = csum_q[7:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept && !full) buf_q[n_q[AW-1:0]] <= payload_in;
   end

   // Accumulator starts from the two port words; the length word is added once in CSUM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         dst_q     <= '0;
         n_q       <= '0;
         rd_q      <= '0;
         acc_q     <= '0;
         len_q     <= '0;
         csum_q    <= '0;
         hdr_idx_q <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         error_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  dst_q   <= dst_port;
                  n_q     <= '0;
                  rd_q    <= '0;
                  acc_q   <= {16'h0, LOCAL_PORT} + {16'h0, dst_port};
                  ready_q <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  if (full) begin
                     error_q <= 1'b1;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     n_q   <= n_q + 1'b1;
                     acc_q <= acc_q + word_add;
                     if (payload_last) begin
                        ready_q <= 1'b0;
                        state_q <= S_CSUM;
                     end
                  end
               end
            end
            S_CSUM: begin
               len_q     <= len_d;
               csum_q    <= ~fold2_d;
               hdr_idx_q <= '0;
               state_q   <= S_HEADER;
            end
            S_HEADER: begin
               data_q    <= hdr_byte;
               valid_q   <= 1'b1;
               hdr_idx_q <= hdr_idx_q + 3'd1;
               if (hdr_idx_q == 3'd7) begin
                  rd_q    <= '0;
                  state_q <= S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               if (rd_q == n_q) begin
                  data_q  <= '0;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  data_q <= rd_byte;
                  rd_q   <= rd_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ready     = ready_q;
   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign busy      = busy_q;
   assign error     = error_q;

endmodule

// File: tb/tb_udp_tx.sv
// Directed bench for udp_tx: a table of datagrams with hand-computed checksums,
// plus overflow, back-to-back, mid-header start and mid-header reset sequences.
module tb_udp_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] dst_port;
   logic [7:0]  payload_in;
   logic        payload_valid_in;
   logic        payload_last;
   logic        ready;
   logic [7:0]  data_out;
   logic        valid_out;
   logic        busy;
   logic        error;

   always #5 clk = ~clk;

   udp_tx dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .dst_port         (dst_port),
      .payload_in       (payload_in),
      .payload_valid_in (payload_valid_in),
      .payload_last     (payload_last),
      .ready            (ready),
      .data_out         (data_out),
      .valid_out        (valid_out),
      .busy             (busy),
      .error            (error)
   );

   typedef struct {
      logic [15:0] dst;
      int          n;
      logic [7:0]  pl [16];
      logic [15:0] csum;
      bit          stall;
      int          mid_start;
      int          rst_at;
   } vec_t;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int valid_seen = 0;
   int err_pulses = 0;

   always @(negedge clk) begin
      if (valid_out) valid_seen++;
      if (error) err_pulses++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic [15:0] dst, input int n, input logic [127:0] bytes,
                               input logic [15:0] csum, input bit stall, input int ms, input int ra);
      vec_t v;
      v.dst = dst; v.n = n; v.csum = csum; v.stall = stall; v.mid_start = ms; v.rst_at = ra;
      for (int i = 0; i < 16; i++) begin
         v.pl[i] = 8'h00;
         if (i < n) v.pl[i] = bytes[8*(n-1-i) +: 8];
      end
      return v;
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge after the last byte is taken.
   task automatic send(input vec_t v);
      start = 1'b1; dst_port = v.dst;
      payload_valid_in = 1'b1; payload_in = 8'hEE; payload_last = 1'b1;
      @(negedge clk);
      start = 1'b0; payload_valid_in = 1'b0; payload_last = 1'b0;
      chk("ready_after_start", 32'(ready), 32'd1);
      chk("busy_after_start", 32'(busy), 32'd1);
      for (int i = 0; i < v.n; i++) begin
         if (v.stall) begin
            payload_valid_in = 1'b0; payload_in = 8'h5A; payload_last = 1'b1;
            @(negedge clk);
            if (i == 3) chk("stall_ready", 32'(ready), 32'd1);
            payload_last = 1'b0;
         end
         payload_in = v.pl[i]; payload_valid_in = 1'b1; payload_last = (i == v.n - 1);
         @(negedge clk);
      end
      payload_valid_in = 1'b0; payload_last = 1'b0;
      chk("ready_after_last", 32'(ready), 32'd0);
      chk("valid_during_csum", 32'(valid_out), 32'd0);
   endtask

   task automatic expect_dgram(input vec_t v);
      logic [7:0]  e [24];
      logic [15:0] len;
      int          snap;
      len = 16'(8 + v.n);
      e[0] = 8'h16; e[1] = 8'h2E; e[2] = v.dst[15:8]; e[3] = v.dst[7:0];
      e[4] = len[15:8]; e[5] = len[7:0]; e[6] = v.csum[15:8]; e[7] = v.csum[7:0];
      for (int i = 0; i < v.n; i++) e[8+i] = v.pl[i];
      @(negedge clk);
      chk("valid_before_header", 32'(valid_out), 32'd0);
      for (int i = 0; i < 8 + v.n; i++) begin
         @(negedge clk);
         chk($sformatf("valid[%0d]", i), 32'(valid_out), 32'd1);
         chk($sformatf("byte[%0d]", i), 32'(data_out), 32'(e[i]));
         start = (i == v.mid_start);
         if (i == v.mid_start) dst_port = 16'hBEEF;
         if (i == v.rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0; start = 1'b0;
            chk("rst_valid", 32'(valid_out), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_ready", 32'(ready), 32'd0);
            chk("rst_data", 32'(data_out), 32'd0);
            snap = valid_seen;
            repeat (4) @(negedge clk);
            chk("rst_no_tail", 32'(valid_seen - snap), 32'd0);
            return;
         end
      end
      @(negedge clk);
      start = 1'b0;
      chk("valid_after_end", 32'(valid_out), 32'd0);
      chk("busy_after_end", 32'(busy), 32'd0);
   endtask

   task automatic do_overflow();
      int vs, es;
      vs = valid_seen; es = err_pulses;
      start = 1'b1; dst_port = 16'h1111;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 65; i++) begin
         payload_in = 8'(i); payload_valid_in = 1'b1; payload_last = 1'b0;
         @(negedge clk);
         if (i == 63) begin
            chk("ovf_no_early_error", 32'(error), 32'd0);
            chk("ovf_busy_at_64", 32'(busy), 32'd1);
         end
      end
      chk("ovf_error", 32'(error), 32'd1);
      chk("ovf_busy", 32'(busy), 32'd0);
      chk("ovf_ready", 32'(ready), 32'd0);
      payload_valid_in = 1'b0;
      @(negedge clk);
      chk("ovf_error_pulse", 32'(error), 32'd0);
      repeat (3) @(negedge clk);
      chk("ovf_no_output", 32'(valid_seen - vs), 32'd0);
      chk("ovf_one_error", 32'(err_pulses - es), 32'd1);
      chk("ovf_busy_after", 32'(busy), 32'd0);
   endtask

   vec_t tbl [8];

   initial begin
      tbl[0] = mk(16'd1234, 5,  128'h48656C6C6F,                       16'hC120, 1'b0, -1, -1);
      tbl[1] = mk(16'd1234, 1,  128'hAA,                               16'h3AF6, 1'b0, -1, -1);
      tbl[2] = mk(16'd8080, 16, 128'h00112233445566778899AABBCCDDEEFF, 16'h0DE6, 1'b1, -1, -1);
      tbl[3] = mk(16'd8080, 4,  128'h54657374,                         16'h025C, 1'b0, -1, -1);
      tbl[4] = mk(16'd1234, 2,  128'h0102,                             16'hE3F3, 1'b0,  2, -1);
      tbl[5] = mk(16'd1234, 2,  128'h0304,                             16'hE1F1, 1'b0, -1, -1);
      tbl[6] = mk(16'h0050, 3,  128'h112233,                           16'hA554, 1'b0, -1,  2);
      tbl[7] = mk(16'hFFFF, 3,  128'hFFFFFF,                           16'hEAC5, 1'b0, -1, -1);

      rst = 1'b1; start = 1'b0; dst_port = '0;
      payload_in = '0; payload_valid_in = 1'b0; payload_last = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_data", 32'(data_out), 32'd0);
      chk("reset_valid", 32'(valid_out), 32'd0);
      chk("reset_ready", 32'(ready), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_error", 32'(error), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 8; t++) begin
         if (t == 3) do_overflow();
         send(tbl[t]);
         expect_dgram(tbl[t]);
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
